bqs_gate_sequencer: RTL and testbench

//  Sequences the sigmoid/tanh bias-quantize-saturate unit across all hidden units of one LSTM gate.
//  - Accepts 32-bit inner-product sums from the MAC array one at a time.
//  - Fetches the matching 8-bit bias from bias SRAM (1-cycle read latency).
//  - Presents sum + bias to the quantizer with the right comb_ctrl code.
//  - Returns each saturated 8-bit result with its unit index over a valid/ready output.

---
 rtl/bqs_gate_sequencer_if.sv | 46 ++++
 rtl/bqs_gate_sequencer.sv | 178 +++++++++++++++++
 tb/tb_bqs_gate_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bqs_gate_sequencer_if.sv
// ============================================================================
// Module : bqs_gate_sequencer_if
// Signal bundle between the gate sequencer and its MAC, SRAM, quantizer and sink.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface bqs_gate_sequencer_if #(
  parameter int unsigned IDX_W = 8
);
  logic             start;
  logic             gate_tanh;
  logic [IDX_W-1:0] num_units;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             bias_rd_en;
  logic [IDX_W-1:0] bias_addr;
  logic [7:0]       bias_rdata;
  logic [4:0]       comb_ctrl;
  logic [31:0]      inpdt_R_reg;
  logic [7:0]       bias_buffer;
  logic [7:0]       q_result;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [15:0]      sat_cnt;

  modport slave (
    input  start, gate_tanh, num_units, in_valid, in_data, bias_rdata, q_result, out_ready,
    output in_ready, bias_rd_en, bias_addr, comb_ctrl, inpdt_R_reg, bias_buffer,
           out_valid, out_data, out_idx, busy, done, sat_cnt
  );

  modport master (
    output start, gate_tanh, num_units, in_valid, in_data, bias_rdata, q_result, out_ready,
    input  in_ready, bias_rd_en, bias_addr, comb_ctrl, inpdt_R_reg, bias_buffer,
           out_valid, out_data, out_idx, busy, done, sat_cnt
  );
endinterface

`default_nettype wire

// File: rtl/bqs_gate_sequencer.sv
// ============================================================================
// Module : bqs_gate_sequencer
// Steps the bias-quantize-saturate unit over every hidden unit of one LSTM gate.
// Optional saturation counter enabled by macro BQS_SAT_CNT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bqs_gate_sequencer #(
  parameter int unsigned IDX_W     = 8,
  parameter logic [4:0]  CODE_IDLE = 5'd0,
  parameter logic [4:0]  CODE_SIG  = 5'd1,
  parameter logic [4:0]  CODE_TANH = 5'd2
) (
  input  logic               clk,
  input  logic               rstn,
  bqs_gate_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_IN = 3'd1,
    BIAS    = 3'd2,
    QUANT   = 3'd3,
    OUT     = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] num_units_q, num_units_d;
  logic             gate_tanh_q, gate_tanh_d;
  logic [31:0]      inpdt_q, inpdt_d;
  logic [7:0]       bias_buf_q, bias_buf_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  logic             in_ready;
  logic             bias_rd_en;
  logic [4:0]       comb_ctrl;
  logic             done;
  logic             last_unit;

  assign last_unit = (idx_q == (num_units_q - IDX_ONE));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_units_d = num_units_q;
    gate_tanh_d = gate_tanh_q;
    inpdt_d     = inpdt_q;
    bias_buf_d  = bias_buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    in_ready    = 1'b0;
    bias_rd_en  = 1'b0;
    comb_ctrl   = CODE_IDLE;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          gate_tanh_d = bus.gate_tanh;
          num_units_d = bus.num_units;
          idx_d       = '0;
          state_d     = (bus.num_units == '0) ? DONE : WAIT_IN;
        end
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          inpdt_d    = bus.in_data;
          bias_rd_en = 1'b1;
          state_d    = BIAS;
        end
      end
      BIAS: begin
        // SRAM data for the read issued on the input handshake lands here.
        bias_buf_d = bus.bias_rdata;
        state_d    = QUANT;
      end
      QUANT: begin
        comb_ctrl   = gate_tanh_q ? CODE_TANH : CODE_SIG;
        out_data_d  = bus.q_result;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (last_unit) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = WAIT_IN;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      num_units_q <= '0;
      gate_tanh_q <= 1'b0;
      inpdt_q     <= '0;
      bias_buf_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_units_q <= num_units_d;
      gate_tanh_q <= gate_tanh_d;
      inpdt_q     <= inpdt_d;
      bias_buf_q  <= bias_buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

`ifdef BQS_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if ((state_q == IDLE) && bus.start) begin
      sat_cnt_d = '0;
    end else if ((state_q == OUT) && bus.out_ready &&
                 ((out_data_q == 8'd0) || (out_data_q == 8'd255)) &&
                 (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign bus.sat_cnt = sat_cnt_q;
`else
  assign bus.sat_cnt = 16'd0;
`endif

  assign bus.in_ready    = in_ready;
  assign bus.bias_rd_en  = bias_rd_en;
  assign bus.bias_addr   = idx_q;
  assign bus.comb_ctrl   = comb_ctrl;
  assign bus.inpdt_R_reg = inpdt_q;
  assign bus.bias_buffer = bias_buf_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done;

endmodule

`default_nettype wire

// File: tb/tb_bqs_gate_sequencer.sv
// ============================================================================
// Module : tb_bqs_gate_sequencer
// Scoreboard bench for bqs_gate_sequencer with a behavioural quantizer and bias SRAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bqs_gate_sequencer;

  localparam int IDX_W = 8;

  typedef struct {
    logic [7:0] data;
    logic [7:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bqs_gate_sequencer_if #(.IDX_W(IDX_W)) bus ();

  bqs_gate_sequencer #(.IDX_W(IDX_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         in_hs_cyc   = -100;
  int         out_hs_cyc  = -100;
  int         exp_idx     = 0;
  int         exp_sat     = 0;
  logic       cur_tanh    = 1'b0;
  exp_t       sb[$];
  logic [7:0] bias_mem [256];
  logic [31:0] sums [8];

  // Reference quantizer: code 1 = (v+128), code 2 = (2v+128), clamped to 0..255;
  // any other code yields a marker value so a wrong opcode shows up in out_data.
  function automatic logic [7:0] quant(input logic [31:0] s, input logic [7:0] b, input logic [4:0] code);
    longint v;
    v = longint'($signed(s)) + longint'($signed(b));
    if (code == 5'd2) v = v * 2;
    else if (code != 5'd1) return 8'h5A;
    v = v + 128;
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  assign bus.q_result = quant(bus.inpdt_R_reg, bus.bias_buffer, bus.comb_ctrl);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.bias_rd_en) bus.bias_rdata <= bias_mem[bus.bias_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output-side monitor: scoreboard pops, hold-under-backpressure, opcode and latency.
  initial begin
    logic       prev_ov, prev_or;
    logic [7:0] prev_data, prev_idx;
    exp_t       e;
    prev_ov = 1'b0; prev_or = 1'b1; prev_data = '0; prev_idx = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_ov   = 1'b0;
        in_hs_cyc = -100;
      end else begin
        if (bus.in_valid && bus.in_ready) in_hs_cyc = cyc;
        if (bus.bias_rd_en || (bus.in_valid && bus.in_ready))
          check("rd_en_on_hs", 64'(bus.bias_rd_en), 64'(bus.in_valid && bus.in_ready));
        if (bus.bias_rd_en) check("bias_addr", 64'(bus.bias_addr), 64'(exp_idx));
        if ((cyc == in_hs_cyc + 2) || (bus.comb_ctrl != 5'd0))
          check("comb_ctrl", 64'(bus.comb_ctrl),
                (cyc == in_hs_cyc + 2) ? (cur_tanh ? 64'd2 : 64'd1) : 64'd0);
        if (bus.out_valid && !prev_ov) check("latency", 64'(cyc - in_hs_cyc), 64'd3);
        if (prev_ov && !prev_or)
          check("hold", {47'd0, bus.out_valid, bus.out_data, bus.out_idx},
                {47'd0, 1'b1, prev_data, prev_idx});
        if (bus.out_valid && bus.out_ready) begin
          out_hs_cyc = cyc;
          if (sb.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("out_data", 64'(bus.out_data), 64'(e.data));
            check("out_idx", 64'(bus.out_idx), 64'(e.idx));
          end
        end
        prev_ov   = bus.out_valid;
        prev_or   = bus.out_ready;
        prev_data = bus.out_data;
        prev_idx  = bus.out_idx;
      end
    end
  end

  task automatic push_exp(input int i, input logic tanh);
    exp_t e;
    e.data = quant(sums[i], bias_mem[i], tanh ? 5'd2 : 5'd1);
    e.idx  = 8'(i);
    sb.push_back(e);
`ifdef BQS_SAT_CNT_EN
    if ((e.data == 8'd0) || (e.data == 8'd255)) exp_sat++;
`endif
  endtask

  task automatic feed(input int i, input logic tanh);
    bit hs;
    hs = 1'b0;
    exp_idx      = i;
    bus.in_valid = 1'b1;
    bus.in_data  = sums[i];
    push_exp(i, tanh);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk); #1;
      if (hs) break;
    end
    if (!hs) check("in_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  task automatic wait_done(input int n, input int start_cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (n == 0 && !bus.done)
        check("idle_pass", {61'd0, bus.in_ready, bus.bias_rd_en, bus.out_valid}, 64'd0);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      check("done_cyc", 64'(cyc), (n == 0) ? 64'(start_cyc + 1) : 64'(out_hs_cyc + 1));
      @(negedge clk);
      check("done_pulse", {62'd0, bus.done, bus.busy}, 64'd0);
    end
    check("sat_cnt", 64'(bus.sat_cnt), 64'(exp_sat));
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_pass(input logic tanh, input int n, input bit bp);
    int start_cyc;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.gate_tanh = tanh;
    bus.num_units = 8'(n);
    cur_tanh      = tanh;
    exp_sat       = 0;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.gate_tanh = ~tanh;
    bus.num_units = 8'hFF;
    check("busy_after_start", 64'(bus.busy), 64'd1);
    check("sat_clr", 64'(bus.sat_cnt), 64'd0);
    if (bp) bus.out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      feed(i, tanh);
      if (i == 0) begin
        // A start while busy must not disturb the latched config.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      if (bp && i == 0) begin
        for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
        check("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_stall", {61'd0, bus.out_valid, bus.in_ready, bus.bias_rd_en}, 64'd4);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    end
    wait_done(n, start_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.gate_tanh = 1'b0;
    bus.num_units = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int a = 0; a < 256; a++) bias_mem[a] = 8'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs",
          {bus.inpdt_R_reg, bus.bias_buffer, bus.out_data, bus.out_idx, bus.bias_addr},
          64'd0);
    check("reset_ctrl",
          {38'd0, bus.sat_cnt, bus.comb_ctrl, bus.in_ready, bus.bias_rd_en,
           bus.out_valid, bus.busy, bus.done}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Sigmoid, zero sums and biases
    sums[0] = 0; sums[1] = 0; sums[2] = 0;
    run_pass(1'b0, 3, 1'b0);

    // Tanh, single unit
    sums[0] = 0;
    run_pass(1'b1, 1, 1'b0);

    // Backpressure with nonzero data
    sums[0] = 32'd5; sums[1] = -32'sd20;
    bias_mem[0] = 8'd3; bias_mem[1] = 8'hFA;
    run_pass(1'b0, 2, 1'b1);

    // Empty pass
    run_pass(1'b0, 0, 1'b0);

    // Reset while in BIAS loses the pass
    sums[0] = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.gate_tanh = 1'b0; bus.num_units = 8'd3; cur_tanh = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    feed(0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_outs",
          {bus.inpdt_R_reg, bus.bias_buffer, bus.out_data, bus.out_idx, bus.bias_addr},
          64'd0);
    check("async_rst_ctrl",
          {38'd0, bus.sat_cnt, bus.comb_ctrl, bus.in_ready, bus.bias_rd_en,
           bus.out_valid, bus.busy, bus.done}, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    sums[0] = 32'd10; sums[1] = -32'sd70;
    bias_mem[0] = 8'd4; bias_mem[1] = 8'd2;
    run_pass(1'b1, 2, 1'b0);

    // Saturating sums
    sums[0] = 32'h4000_0000; sums[1] = 32'hC000_0000; sums[2] = 0;
    bias_mem[0] = 8'd0; bias_mem[1] = 8'd0; bias_mem[2] = 8'd7;
    run_pass(1'b0, 3, 1'b0);
    run_pass(1'b0, 0, 1'b0);

    // Random tanh pass
    for (int i = 0; i < 6; i++) begin
      sums[i]     = 32'($urandom_range(0, 200)) - 32'd100;
      bias_mem[i] = 8'($urandom_range(0, 255));
    end
    run_pass(1'b1, 6, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
